// File: rtl/ball_paddle_engine_if.sv
// Signal bundle between the game controller and the ball/paddle core.
// The controller drives frame timing, serve and paddle positions.
// The core returns ball coordinates, scores and point/game-over status.
interface ball_paddle_engine_if #(
  parameter int COORD_W = 11,
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               serve;
  logic [COORD_W-1:0] pad_l_y;
  logic [COORD_W-1:0] pad_r_y;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               point_l;
  logic               point_r;
  logic               game_over;

  modport master (
    output frame_tick, serve, pad_l_y, pad_r_y,
    input  ball_x, ball_y, score_l, score_r, point_l, point_r, game_over
  );

  modport slave (
    input  frame_tick, serve, pad_l_y, pad_r_y,
    output ball_x, ball_y, score_l, score_r, point_l, point_r, game_over
  );
endinterface

// File: rtl/ball_paddle_engine.sv
// Frame-rate ball-and-paddle game core. Once per frame_tick it moves the
// ball and bounces it off the walls and both paddles, with speed-up on
// every paddle hit. It also scores misses, freezes the ball after a point
// and sequences serve / game over.
module ball_paddle_engine #(
  parameter int COORD_W     = 11,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PAD_W       = 8,
  parameter int PAD_H       = 64,
  parameter int PAD_X_L     = 16,
  parameter int PAD_X_R     = 616,
  parameter int SPEED_MAX   = 6,
  parameter int HOLD_FRAMES = 60,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ball_paddle_engine_if.slave  bus
);
  // Two extra bits so that x+dx / y+dy can go negative or past the field
  // without wrapping.
  localparam int SW    = COORD_W + 2;
  localparam int VEL_W = $clog2(SPEED_MAX + 1) + 1;
  localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [COORD_W-1:0] X_CENTRE = COORD_W'(H_RES / 2 - BALL_SIZE / 2);
  localparam logic [COORD_W-1:0] Y_CENTRE = COORD_W'(V_RES / 2 - BALL_SIZE / 2);
  localparam logic [COORD_W-1:0] X_HIT_L  = COORD_W'(PAD_X_L + PAD_W);
  localparam logic [COORD_W-1:0] X_HIT_R  = COORD_W'(PAD_X_R - BALL_SIZE);
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(V_RES - BALL_SIZE);

  localparam logic signed [SW-1:0] S_ZERO   = '0;
  localparam logic signed [SW-1:0] S_HIT_L  = SW'(PAD_X_L + PAD_W);
  localparam logic signed [SW-1:0] S_PAD_XR = SW'(PAD_X_R);
  localparam logic signed [SW-1:0] S_BALL   = SW'(BALL_SIZE);
  localparam logic signed [SW-1:0] S_PAD_H  = SW'(PAD_H);
  localparam logic signed [SW-1:0] S_X_MAX  = SW'(H_RES - BALL_SIZE);
  localparam logic signed [SW-1:0] S_Y_MAX  = SW'(V_RES - BALL_SIZE);

  localparam logic signed [VEL_W-1:0] V_ONE  = VEL_W'(1);
  localparam logic        [VEL_W-1:0] V_UNIT = VEL_W'(1);
  localparam logic        [VEL_W-1:0] V_MAX  = VEL_W'(SPEED_MAX);
  localparam logic [SCORE_W-1:0] W_SCORE = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] S_UNIT  = SCORE_W'(1);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0]   C_UNIT    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PLAY, SCORED, OVER} state_t;

  state_t                   state_q, state_n;
  logic [COORD_W-1:0]       ball_x_q, ball_x_n, ball_y_q, ball_y_n;
  logic signed [VEL_W-1:0]  dx_q, dx_n, dy_q, dy_n;
  logic [SCORE_W-1:0]       score_l_q, score_l_n, score_r_q, score_r_n;
  logic [CNT_W-1:0]         cnt_q, cnt_n;
  logic                     point_l_q, point_l_n, point_r_q, point_r_n;

  logic signed [SW-1:0] bx_s, by_s, dx_s, dy_s, nx, ny, pl_s, pr_s;
  logic                 dx_neg, dx_pos, hit_l, hit_r;

  // Magnitude of the next speed after a paddle hit, capped at SPEED_MAX.
  function automatic logic [VEL_W-1:0] speed_up(input logic signed [VEL_W-1:0] v);
    logic [VEL_W-1:0] mag;
    mag = v[VEL_W-1] ? -v : v;
    speed_up = (mag >= V_MAX) ? V_MAX : mag + V_UNIT;
  endfunction

  // Score increment that sticks at WIN_SCORE.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    score_inc = (s >= W_SCORE) ? W_SCORE : s + S_UNIT;
  endfunction

  assign bx_s   = $signed({2'b00, ball_x_q});
  assign by_s   = $signed({2'b00, ball_y_q});
  assign dx_s   = $signed({{(SW - VEL_W){dx_q[VEL_W-1]}}, dx_q});
  assign dy_s   = $signed({{(SW - VEL_W){dy_q[VEL_W-1]}}, dy_q});
  assign pl_s   = $signed({2'b00, bus.pad_l_y});
  assign pr_s   = $signed({2'b00, bus.pad_r_y});
  assign nx     = bx_s + dx_s;
  assign ny     = by_s + dy_s;
  assign dx_neg = dx_q[VEL_W-1];
  assign dx_pos = !dx_q[VEL_W-1] && (dx_q != '0);

  // A paddle only counts when the ball crosses its face this frame, so a
  // ball already past the face carries on to the miss edge.
  assign hit_l = dx_neg && (bx_s >= S_HIT_L) && (nx < S_HIT_L) &&
                 (ny + S_BALL > pl_s) && (ny < pl_s + S_PAD_H);
  assign hit_r = dx_pos && (bx_s + S_BALL <= S_PAD_XR) && (nx + S_BALL > S_PAD_XR) &&
                 (ny + S_BALL > pr_s) && (ny < pr_s + S_PAD_H);

  // Next-state and per-frame ball/score update.
  always_comb begin
    state_n   = state_q;
    ball_x_n  = ball_x_q;
    ball_y_n  = ball_y_q;
    dx_n      = dx_q;
    dy_n      = dy_q;
    score_l_n = score_l_q;
    score_r_n = score_r_q;
    cnt_n     = cnt_q;
    point_l_n = 1'b0;
    point_r_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.serve) state_n = PLAY;
      end
      OVER: begin
        if (bus.serve) begin
          state_n   = PLAY;
          score_l_n = '0;
          score_r_n = '0;
        end
      end
      PLAY: begin
        if (bus.frame_tick) begin
          // Vertical walls are independent of the paddle test: a corner hit
          // applies both.
          if (ny <= S_ZERO) begin
            ball_y_n = '0;
            dy_n     = -dy_q;
          end else if (ny >= S_Y_MAX) begin
            ball_y_n = Y_MAX;
            dy_n     = -dy_q;
          end else begin
            ball_y_n = ny[COORD_W-1:0];
          end
          if (hit_l) begin
            ball_x_n = X_HIT_L;
            dx_n     = $signed(speed_up(dx_q));
          end else if (hit_r) begin
            ball_x_n = X_HIT_R;
            dx_n     = -$signed(speed_up(dx_q));
          end else if (nx <= S_ZERO) begin
            ball_x_n  = '0;
            score_r_n = score_inc(score_r_q);
            point_r_n = 1'b1;
            cnt_n     = '0;
            state_n   = SCORED;
          end else if (nx >= S_X_MAX) begin
            ball_x_n  = X_MAX;
            score_l_n = score_inc(score_l_q);
            point_l_n = 1'b1;
            cnt_n     = '0;
            state_n   = SCORED;
          end else begin
            ball_x_n = nx[COORD_W-1:0];
          end
        end
      end
      SCORED: begin
        if (bus.frame_tick) begin
          if (cnt_q == HOLD_LAST) begin
            // dx still points at the side that missed, so the re-serve
            // heads toward the player who conceded.
            ball_x_n = X_CENTRE;
            ball_y_n = Y_CENTRE;
            dx_n     = dx_neg ? -V_ONE : V_ONE;
            cnt_n    = '0;
            state_n  = (score_l_q == W_SCORE || score_r_q == W_SCORE) ? OVER : PLAY;
          end else begin
            cnt_n = cnt_q + C_UNIT;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and game registers; reset overrides any serve or tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ball_x_q  <= X_CENTRE;
      ball_y_q  <= Y_CENTRE;
      dx_q      <= V_ONE;
      dy_q      <= V_ONE;
      score_l_q <= '0;
      score_r_q <= '0;
      cnt_q     <= '0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      ball_x_q  <= ball_x_n;
      ball_y_q  <= ball_y_n;
      dx_q      <= dx_n;
      dy_q      <= dy_n;
      score_l_q <= score_l_n;
      score_r_q <= score_r_n;
      cnt_q     <= cnt_n;
      point_l_q <= point_l_n;
      point_r_q <= point_r_n;
    end
  end

  assign bus.ball_x    = ball_x_q;
  assign bus.ball_y    = ball_y_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.point_l   = point_l_q;
  assign bus.point_r   = point_r_q;
  assign bus.game_over = (state_q == OVER);
endmodule

// File: tb/tb_ball_paddle_engine.sv
// Bench for ball_paddle_engine. A behavioural game model tracks the
// expected ball, scores and status from the rules, using plain integers.
// Each scenario task drives the core and compares against that model or
// against fixed values.
module tb_ball_paddle_engine;
  localparam int COORD_W = 11;
  localparam int SCORE_W = 4;
  localparam logic [32:0] RESET_VEC = {11'd316, 11'd236, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ball_paddle_engine_if #(.COORD_W(COORD_W), .SCORE_W(SCORE_W)) bus ();

  ball_paddle_engine #(
    .COORD_W(COORD_W), .H_RES(640), .V_RES(480), .BALL_SIZE(8), .PAD_W(8),
    .PAD_H(64), .PAD_X_L(16), .PAD_X_R(616), .SPEED_MAX(6),
    .HOLD_FRAMES(60), .WIN_SCORE(9), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [32:0] obs;
  assign obs = {bus.ball_x, bus.ball_y, bus.score_l, bus.score_r,
                bus.point_l, bus.point_r, bus.game_over};

  // Game model: rally in progress, frozen countdown after a point, finished.
  int m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_freeze;
  bit m_rally, m_done, m_left_lost, m_pl, m_pr;

  task automatic model_clock(input bit r, input bit tick, input bit srv,
                             input int pl, input int pr);
    int nx, ny, spd;
    bit hl, hr;
    m_pl = 1'b0;
    m_pr = 1'b0;
    if (!r) begin
      m_x = 316; m_y = 236; m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0;
      m_freeze = 0; m_rally = 0; m_done = 0; m_left_lost = 0;
      return;
    end
    if (!m_rally && m_freeze == 0) begin
      if (srv) begin
        if (m_done) begin m_sl = 0; m_sr = 0; end
        m_done = 0;
        m_rally = 1;
      end
      return;
    end
    if (!tick) return;
    if (m_rally) begin
      nx = m_x + m_dx;
      ny = m_y + m_dy;
      spd = ((m_dx < 0) ? -m_dx : m_dx) + 1;
      if (spd > 6) spd = 6;
      hl = (m_dx < 0) && (m_x >= 24) && (nx < 24) && (ny + 8 > pl) && (ny < pl + 64);
      hr = (m_dx > 0) && (m_x + 8 <= 616) && (nx + 8 > 616) && (ny + 8 > pr) && (ny < pr + 64);
      if (ny <= 0) begin m_y = 0; m_dy = -m_dy; end
      else if (ny >= 472) begin m_y = 472; m_dy = -m_dy; end
      else m_y = ny;
      if (hl) begin m_x = 24; m_dx = spd; end
      else if (hr) begin m_x = 608; m_dx = -spd; end
      else if (nx <= 0) begin
        m_x = 0; if (m_sr < 9) m_sr++; m_pr = 1;
        m_rally = 0; m_freeze = 60; m_left_lost = 1;
      end else if (nx >= 632) begin
        m_x = 632; if (m_sl < 9) m_sl++; m_pl = 1;
        m_rally = 0; m_freeze = 60; m_left_lost = 0;
      end else m_x = nx;
    end else begin
      m_freeze--;
      if (m_freeze == 0) begin
        m_x = 316; m_y = 236;
        m_dx = m_left_lost ? -1 : 1;
        if (m_sl == 9 || m_sr == 9) m_done = 1;
        else m_rally = 1;
      end
    end
  endtask

  function automatic logic [32:0] model_vec();
    return {11'(m_x), 11'(m_y), 4'(m_sl), 4'(m_sr), m_pl, m_pr, m_done};
  endfunction

  // Paddle that always covers the ball / that never does.
  function automatic logic [10:0] track(input int y);
    return 11'((y >= 28) ? y - 28 : 0);
  endfunction
  function automatic logic [10:0] avoid(input int y);
    return (y >= 240) ? 11'd0 : 11'd400;
  endfunction

  task automatic cycle(input bit r, input bit tick, input bit srv);
    rst = r;
    bus.frame_tick = tick;
    bus.serve = srv;
    @(posedge clk);
    model_clock(r, tick, srv, int'(bus.pad_l_y), int'(bus.pad_r_y));
    @(negedge clk);
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.serve = 1'b0;
  endtask

  task automatic test_reset();
    bus.pad_l_y = '0;
    bus.pad_r_y = '0;
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL reset: got %h want %h", obs, RESET_VEC);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== RESET_VEC) begin
        errors++; $display("FAIL idle_tick %0d: got %h want %h", i, obs, RESET_VEC);
      end
    end
  endtask

  task automatic test_walls_and_hits();
    int min_x = 9999, max_x = 0, min_y = 9999, max_y = 0, max_step = 0, prev_x, step;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2600; i++) begin
      bit t;
      bus.pad_l_y = track(m_y);
      bus.pad_r_y = track(m_y);
      t = ($urandom_range(0, 3) != 0);
      prev_x = int'(bus.ball_x);
      cycle(1'b1, t, ($urandom_range(0, 7) == 0));
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL rally %0d: got %h want %h", i, obs, model_vec());
      end
      if (int'(bus.ball_x) < min_x) min_x = int'(bus.ball_x);
      if (int'(bus.ball_x) > max_x) max_x = int'(bus.ball_x);
      if (int'(bus.ball_y) < min_y) min_y = int'(bus.ball_y);
      if (int'(bus.ball_y) > max_y) max_y = int'(bus.ball_y);
      step = int'(bus.ball_x) - prev_x;
      if (step < 0) step = -step;
      if (step > max_step) max_step = step;
    end
    checks++;
    if (min_y != 0) begin errors++; $display("FAIL top_wall: got %0d want 0", min_y); end
    checks++;
    if (max_y != 472) begin errors++; $display("FAIL bottom_wall: got %0d want 472", max_y); end
    checks++;
    if (min_x != 24) begin errors++; $display("FAIL left_hit_x: got %0d want 24", min_x); end
    checks++;
    if (max_x != 608) begin errors++; $display("FAIL right_hit_x: got %0d want 608", max_x); end
    checks++;
    if (max_step != 6) begin errors++; $display("FAIL speed_sat: got %0d want 6", max_step); end
  endtask

  task automatic test_miss_and_hold();
    int fy;
    bit seen = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2000 && !seen; i++) begin
      bus.pad_l_y = avoid(m_y);
      bus.pad_r_y = track(m_y);
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL to_miss %0d: got %h want %h", i, obs, model_vec());
      end
      if (bus.point_l || bus.point_r) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL miss_timeout: got no point want point_r"); end
    checks++;
    if ({bus.point_r, bus.point_l, bus.score_r, bus.ball_x} !== {1'b1, 1'b0, 4'd1, 11'd0}) begin
      errors++;
      $display("FAIL left_miss: got pr=%b pl=%b sr=%0d x=%0d want 1 0 1 0",
               bus.point_r, bus.point_l, bus.score_r, bus.ball_x);
    end
    fy = int'(bus.ball_y);
    for (int i = 0; i < 59; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if ({bus.ball_x, bus.ball_y, bus.point_r} !== {11'd0, 11'(fy), 1'b0}) begin
        errors++;
        $display("FAIL frozen %0d: got x=%0d y=%0d pr=%b want 0 %0d 0",
                 i, bus.ball_x, bus.ball_y, bus.point_r, fy);
      end
    end
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if ({bus.ball_x, bus.ball_y} !== {11'd316, 11'd236}) begin
      errors++; $display("FAIL recentre: got %0d,%0d want 316,236", bus.ball_x, bus.ball_y);
    end
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.ball_x !== 11'd315) begin
      errors++; $display("FAIL serve_dir: got %0d want 315", bus.ball_x);
    end
  endtask

  task automatic test_win_and_restart();
    for (int i = 0; i < 9000 && bus.game_over !== 1'b1; i++) begin
      bus.pad_l_y = avoid(m_y);
      bus.pad_r_y = track(m_y);
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL to_win %0d: got %h want %h", i, obs, model_vec());
      end
    end
    checks++;
    if ({bus.game_over, bus.score_l, bus.score_r} !== {1'b1, 4'd0, 4'd9}) begin
      errors++;
      $display("FAIL win: got over=%b sl=%0d sr=%0d want 1 0 9",
               bus.game_over, bus.score_l, bus.score_r);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL over_tick %0d: got %h want %h", i, obs, model_vec());
      end
    end
    cycle(1'b1, 1'b0, 1'b1);
    checks++;
    if ({bus.game_over, bus.score_l, bus.score_r} !== {1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL restart: got over=%b sl=%0d sr=%0d want 0 0 0",
               bus.game_over, bus.score_l, bus.score_r);
    end
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.ball_x !== 11'd315) begin
      errors++; $display("FAIL restart_move: got %0d want 315", bus.ball_x);
    end
  endtask

  task automatic test_reset_mid_scored();
    bit seen = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 1000 && !seen; i++) begin
      bus.pad_l_y = avoid(m_y);
      bus.pad_r_y = avoid(m_y);
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL to_scored %0d: got %h want %h", i, obs, model_vec());
      end
      if (bus.point_l || bus.point_r) seen = 1'b1;
    end
    checks++;
    if (bus.point_l !== 1'b1) begin
      errors++; $display("FAIL right_miss: got point_l=%b want 1", bus.point_l);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL reset_mid: got %h want %h", obs, RESET_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== RESET_VEC) begin
        errors++; $display("FAIL post_reset_idle %0d: got %h want %h", i, obs, RESET_VEC);
      end
    end
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if ({bus.ball_x, bus.ball_y} !== {11'd317, 11'd237}) begin
      errors++; $display("FAIL first_move: got %0d,%0d want 317,237", bus.ball_x, bus.ball_y);
    end
  endtask

  task automatic test_random();
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8000; i++) begin
      bus.pad_l_y = 11'($urandom_range(0, 416));
      bus.pad_r_y = 11'($urandom_range(0, 416));
      cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 15) == 0));
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL random %0d: got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.frame_tick = 1'b0;
    bus.serve = 1'b0;
    bus.pad_l_y = '0;
    bus.pad_r_y = '0;
    test_reset();
    test_walls_and_hits();
    test_miss_and_hold();
    test_win_and_restart();
    test_reset_mid_scored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
